// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    // A request faults when it is not word aligned or its word index lies past the array.
    function automatic logic addr_fault(input logic [WORD_W-1:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= WORD_W'(depth));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store handshake between the pipeline memory stage (master) and the responder (slave).
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_i;
    logic              we_i;
    logic [WORD_W-1:0] addr_i;
    logic [WORD_W-1:0] wdata_i;
    logic              ready_o;
    logic              resp_valid_o;
    logic [WORD_W-1:0] rdata_o;
    logic              err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ready_o, resp_valid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ready_o, resp_valid_o, rdata_o, err_o
    );

endinterface

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM; read-before-write, contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (en) begin
            if (we) begin
                mem_q[index] <= wdata;
            end
            rdata <= mem_q[index];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the load/store interface: holds each request for LATENCY cycles,
// then performs the access and returns a one-cycle response pulse.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              err_q, err_d;
    logic              load_q, load_d;

    logic              enter_resp;
    logic              acc_we;
    logic [WORD_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic              acc_fault;
    logic              acc_en;
    logic [WORD_W-1:0] arr_rdata;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        err_d        = 1'b0;
        load_d       = 1'b0;
        enter_resp   = 1'b0;
        acc_we       = we_q;
        acc_addr     = addr_q;
        acc_wdata    = wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    we_d      = bus.we_i;
                    addr_d    = bus.addr_i;
                    wdata_d   = bus.wdata_i;
                    // With single-cycle latency the access happens on the accepting edge itself.
                    acc_we    = bus.we_i;
                    acc_addr  = bus.addr_i;
                    acc_wdata = bus.wdata_i;
                    if (LATENCY == 1) begin
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        acc_fault = addr_fault(acc_addr, DEPTH_WORDS);
        if (enter_resp) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            err_d        = acc_fault;
            load_d       = !acc_fault && !acc_we;
        end
        // Reset must stop a pending store from ever reaching the array.
        acc_en = enter_resp && !acc_fault && !rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            load_q       <= load_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i (clk_i),
        .en    (acc_en),
        .we    (acc_we),
        .index (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    assign bus.ready_o      = (state_q == IDLE);
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.err_o        = err_q;
    assign bus.rdata_o      = load_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a timestamp-based reference model checked every cycle on two
// builds (LATENCY=4 and LATENCY=1), plus directed requests with literal expectations.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT0  = 4;
    localparam int LAT1  = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        reqD[2];
    logic        weD[2];
    logic [31:0] addrD[2];
    logic [31:0] wdataD[2];
    logic        readyO[2];
    logic        respO[2];
    logic        errO[2];
    logic [31:0] rdataO[2];

    dmem_responder_if busA ();
    dmem_responder_if busB ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) dutA (.clk_i(clk), .rst_i(rst), .bus(busA));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) dutB (.clk_i(clk), .rst_i(rst), .bus(busB));

    assign busA.req_i   = reqD[0];
    assign busA.we_i    = weD[0];
    assign busA.addr_i  = addrD[0];
    assign busA.wdata_i = wdataD[0];
    assign busB.req_i   = reqD[1];
    assign busB.we_i    = weD[1];
    assign busB.addr_i  = addrD[1];
    assign busB.wdata_i = wdataD[1];
    assign readyO[0] = busA.ready_o;
    assign respO[0]  = busA.resp_valid_o;
    assign errO[0]   = busA.err_o;
    assign rdataO[0] = busA.rdata_o;
    assign readyO[1] = busB.ready_o;
    assign respO[1]  = busB.resp_valid_o;
    assign errO[1]   = busB.err_o;
    assign rdataO[1] = busB.rdata_o;

    function automatic int latOf(input int c);
        return (c == 0) ? LAT0 : LAT1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: a request accepted on edge n is performed on edge n+L-1, its response
    // is visible after that edge, and the responder is free again after edge n+L.
    int          edgeN = 0;
    bit          checkEn = 0;
    bit          active[2];
    int          acc[2];
    bit          pWe[2];
    logic [31:0] pAddr[2];
    logic [31:0] pWdata[2];
    int          respEdge[2];
    logic [31:0] expRd[2];
    logic        expErr[2];
    logic [31:0] mdl[2][DEPTH];
    logic [31:0] lastRd[2];

    initial begin
        bit readyPrev;
        for (int c = 0; c < 2; c++) begin
            active[c]   = 0;
            respEdge[c] = -1;
        end
        forever begin
            @(posedge clk);
            edgeN++;
            for (int c = 0; c < 2; c++) begin
                if (rst) begin
                    active[c]   = 0;
                    respEdge[c] = -1;
                    checkEn     = 1;
                end else begin
                    readyPrev = !active[c] || (edgeN - 1 >= acc[c] + latOf(c));
                    if (readyPrev && reqD[c]) begin
                        active[c] = 1;
                        acc[c]    = edgeN;
                        pWe[c]    = weD[c];
                        pAddr[c]  = addrD[c];
                        pWdata[c] = wdataD[c];
                    end
                    if (active[c] && edgeN == acc[c] + latOf(c) - 1) begin
                        respEdge[c] = edgeN;
                        if ((pAddr[c] % 4 != 0) || (pAddr[c] / 4 >= DEPTH)) begin
                            expErr[c] = 1'b1;
                            expRd[c]  = 32'h0;
                        end else if (pWe[c]) begin
                            mdl[c][pAddr[c] / 4] = pWdata[c];
                            expErr[c] = 1'b0;
                            expRd[c]  = 32'h0;
                        end else begin
                            expErr[c] = 1'b0;
                            expRd[c]  = mdl[c][pAddr[c] / 4];
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit eResp;
        bit eReady;
        forever begin
            @(negedge clk);
            if (checkEn) begin
                for (int c = 0; c < 2; c++) begin
                    eResp  = (respEdge[c] == edgeN);
                    eReady = !active[c] || (edgeN >= acc[c] + latOf(c));
                    checkOutput($sformatf("ch%0d ready edge%0d", c, edgeN), 32'(readyO[c]), 32'(eReady));
                    checkOutput($sformatf("ch%0d resp_valid edge%0d", c, edgeN), 32'(respO[c]), 32'(eResp));
                    checkOutput($sformatf("ch%0d err edge%0d", c, edgeN), 32'(errO[c]), eResp ? 32'(expErr[c]) : 32'h0);
                    checkOutput($sformatf("ch%0d rdata edge%0d", c, edgeN), rdataO[c], eResp ? expRd[c] : 32'h0);
                    if (respO[c] === 1'b1) lastRd[c] = rdataO[c];
                end
            end
        end
    end

    task automatic applyStimulus(input int c, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, output int accEdge);
        bit done = 0;
        reqD[c]   = 1'b1;
        weD[c]    = we;
        addrD[c]  = addr;
        wdataD[c] = wdata;
        accEdge   = -1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (readyO[c] === 1'b1) begin
                @(posedge clk);
                #1;
                accEdge = edgeN;
                reqD[c] = 1'b0;
                done    = 1;
            end
        end
        if (!done) begin
            reqD[c] = 1'b0;
            checks++;
            errors++;
            $display("[TB] FAIL ch%0d accept timeout addr=%h actual=not-accepted expected=accepted", c, addr);
        end
    endtask

    task automatic waitResp(input int c, input int accEdge, output int lat,
                            output logic [31:0] rd, output logic er);
        bit found = 0;
        lat = -1;
        rd  = 32'hx;
        er  = 1'bx;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (respO[c] === 1'b1) begin
                lat   = edgeN - accEdge + 1;
                rd    = rdataO[c];
                er    = errO[c];
                found = 1;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL ch%0d response timeout actual=none expected=resp_valid", c);
        end
    endtask

    task automatic pulseReset(input int negedges);
        repeat (negedges) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a1, a2, lat;
        logic [31:0] rd;
        logic er;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            reqD[c] = 1'b0; weD[c] = 1'b0; addrD[c] = 32'h0; wdataD[c] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset ready", 32'(readyO[0]), 32'h1);
        checkOutput("reset resp_valid", 32'(respO[0]), 32'h0);

        $display("[TB] load after preloading mem[4]");
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, a1);
        waitResp(0, a1, lat, rd, er);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, a1);
        waitResp(0, a1, lat, rd, er);
        checkOutput("load 0x10 latency", lat, 32'd4);
        checkOutput("load 0x10 rdata", rd, 32'hDEADBEEF);
        checkOutput("load 0x10 err", 32'(er), 32'h0);

        $display("[TB] store then back-to-back load");
        applyStimulus(0, 1'b1, 32'h20, 32'h12345678, a1);
        applyStimulus(0, 1'b0, 32'h20, 32'h0, a2);
        checkOutput("b2b accept gap", a2 - a1, 32'd5);
        waitResp(0, a2, lat, rd, er);
        checkOutput("b2b load rdata", rd, 32'h12345678);

        $display("[TB] request held through BUSY with another address");
        applyStimulus(0, 1'b0, 32'h10, 32'h0, a1);
        applyStimulus(0, 1'b0, 32'h20, 32'h0, a2);
        checkOutput("held first rdata", lastRd[0], 32'hDEADBEEF);
        checkOutput("held accept gap", a2 - a1, 32'd5);
        waitResp(0, a2, lat, rd, er);
        checkOutput("held second rdata", rd, 32'h12345678);

        $display("[TB] faulting requests");
        applyStimulus(0, 1'b1, 32'h0, 32'hCAFEF00D, a1);
        waitResp(0, a1, lat, rd, er);
        applyStimulus(0, 1'b0, 32'h22, 32'h0, a1);
        waitResp(0, a1, lat, rd, er);
        checkOutput("misaligned err", 32'(er), 32'h1);
        checkOutput("misaligned rdata", rd, 32'h0);
        applyStimulus(0, 1'b1, 32'h400, 32'h11111111, a1);
        waitResp(0, a1, lat, rd, er);
        checkOutput("out of range err", 32'(er), 32'h1);
        checkOutput("out of range rdata", rd, 32'h0);
        applyStimulus(0, 1'b1, 32'h8000_0000, 32'h22222222, a1);
        waitResp(0, a1, lat, rd, er);
        checkOutput("high addr err", 32'(er), 32'h1);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, a1);
        waitResp(0, a1, lat, rd, er);
        checkOutput("mem[0] unchanged", rd, 32'hCAFEF00D);

        $display("[TB] reset while BUSY");
        applyStimulus(0, 1'b1, 32'h8, 32'h0BADF00D, a1);
        waitResp(0, a1, lat, rd, er);
        applyStimulus(0, 1'b1, 32'h8, 32'hAAAA5555, a1);
        pulseReset(2);
        @(negedge clk);
        checkOutput("ready after reset", 32'(readyO[0]), 32'h1);
        applyStimulus(0, 1'b0, 32'h8, 32'h0, a1);
        waitResp(0, a1, lat, rd, er);
        checkOutput("abandoned store busy", rd, 32'h0BADF00D);

        $display("[TB] reset on the edge that would enter RESP");
        applyStimulus(0, 1'b1, 32'hC, 32'h00000066, a1);
        waitResp(0, a1, lat, rd, er);
        applyStimulus(0, 1'b1, 32'hC, 32'h00000077, a1);
        pulseReset(3);
        applyStimulus(0, 1'b0, 32'hC, 32'h0, a1);
        waitResp(0, a1, lat, rd, er);
        checkOutput("abandoned store resp edge", rd, 32'h00000066);

        $display("[TB] idle input changes without req");
        weD[0] = 1'b1; addrD[0] = 32'h10; wdataD[0] = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        addrD[0] = 32'h20; wdataD[0] = 32'h0;
        repeat (3) @(negedge clk);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, a1);
        waitResp(0, a1, lat, rd, er);
        checkOutput("idle wiggle rdata", rd, 32'hDEADBEEF);

        $display("[TB] LATENCY=1 build");
        applyStimulus(1, 1'b1, 32'h4, 32'h00000005, a1);
        waitResp(1, a1, lat, rd, er);
        checkOutput("L1 store latency", lat, 32'd1);
        applyStimulus(1, 1'b0, 32'h4, 32'h0, a1);
        waitResp(1, a1, lat, rd, er);
        checkOutput("L1 load latency", lat, 32'd1);
        checkOutput("L1 load rdata", rd, 32'h00000005);
        @(negedge clk);
        checkOutput("L1 ready returns", 32'(readyO[1]), 32'h1);
        applyStimulus(1, 1'b0, 32'h4, 32'h0, a1);
        applyStimulus(1, 1'b0, 32'h6, 32'h0, a2);
        checkOutput("L1 accept gap", a2 - a1, 32'd2);
        waitResp(1, a2, lat, rd, er);
        checkOutput("L1 misaligned err", 32'(er), 32'h1);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
